// File: rtl/addpipe_hs.sv
// Two-stage split-carry adder (A+B+cin) with valid/ready handshake on both sides.
// Define ADDPIPE_SAT_EN to clamp the result to all ones on carry-out.
module addpipe_hs #(
    parameter  int LS_WIDTH = 32,
    parameter  int MS_WIDTH = 32,
    localparam int WIDTH    = LS_WIDTH + MS_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] datao,
    output logic             cout,
    output logic             sat
);

    logic                r_s1_valid;
    logic [LS_WIDTH:0]   r_ls_sum;
    logic [MS_WIDTH-1:0] r_msa;
    logic [MS_WIDTH-1:0] r_msb;

    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_datao;
    logic                r_cout;

    logic                w_s1_load;
    logic                w_s2_load;
    logic [LS_WIDTH:0]   w_ls_sum;
    logic [MS_WIDTH:0]   w_ms_sum;

    // in_ready looks straight through to out_ready so a full pipe streams with no bubble
    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_s1_load = in_valid & in_ready;

    assign w_ls_sum = {1'b0, dataa[LS_WIDTH-1:0]} + {1'b0, datab[LS_WIDTH-1:0]}
                    + {{LS_WIDTH{1'b0}}, cin};
    assign w_ms_sum = {1'b0, r_msa} + {1'b0, r_msb} + {{MS_WIDTH{1'b0}}, r_ls_sum[LS_WIDTH]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_ls_sum   <= '0;
            r_msa      <= '0;
            r_msb      <= '0;
        end else begin
            r_s1_valid <= w_s1_load | (r_s1_valid & ~w_s2_load);
            if (w_s1_load) begin
                r_ls_sum <= w_ls_sum;
                r_msa    <= dataa[WIDTH-1:LS_WIDTH];
                r_msb    <= datab[WIDTH-1:LS_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_datao    <= '0;
            r_cout     <= 1'b0;
        end else begin
            r_s2_valid <= w_s2_load | (r_s2_valid & ~out_ready);
            if (w_s2_load) begin
                r_cout <= w_ms_sum[MS_WIDTH];
`ifdef ADDPIPE_SAT_EN
                r_datao <= w_ms_sum[MS_WIDTH] ? '1 : {w_ms_sum[MS_WIDTH-1:0], r_ls_sum[LS_WIDTH-1:0]};
`else
                r_datao <= {w_ms_sum[MS_WIDTH-1:0], r_ls_sum[LS_WIDTH-1:0]};
`endif
            end
        end
    end

`ifdef ADDPIPE_SAT_EN
    logic r_sat;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sat <= 1'b0;
        end else if (w_s2_load) begin
            r_sat <= w_ms_sum[MS_WIDTH];
        end
    end

    assign sat = r_sat;
`else
    assign sat = 1'b0;
`endif

    assign out_valid = r_s2_valid;
    assign datao     = r_datao;
    assign cout      = r_cout;

endmodule

// File: tb/tb_addpipe_hs.sv
// Self-checking bench for addpipe_hs: directed vectors, backpressure, random streaming, mid-op reset.
// Build with ADDPIPE_SAT_EN defined to exercise the saturating variant.
module tb_addpipe_hs;
    localparam int LS = 32;
    localparam int MS = 32;
    localparam int W  = LS + MS;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dataa = '0;
    logic [W-1:0] datab = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] datao;
    logic         cout;
    logic         sat;

    int checks = 0;
    int errors = 0;

    // expected result packed as {sat, cout, datao}
    logic [W+1:0] q[$];

    addpipe_hs #(.LS_WIDTH(LS), .MS_WIDTH(MS)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .datao(datao), .cout(cout), .sat(sat)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W+1:0] got, input logic [W+1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        ovf = s[W];
`ifdef ADDPIPE_SAT_EN
        if (ovf) s[W-1:0] = '1;
        return {ovf, ovf, s[W-1:0]};
`else
        return {1'b0, ovf, s[W-1:0]};
`endif
    endfunction

    // Compare process: the queue holds exactly the samples inside the DUT at each negedge
    always @(negedge clock) begin
        if (reset_n) begin
            check("in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, (q.size() < 2) || out_ready});
            if (q.size() == 0)
                check("idle_out_valid", {{(W+1){1'b0}}, out_valid}, '0);
            else if (out_valid) begin
                check("stream_data", {sat, cout, datao}, q[0]);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(dataa, datab, cin));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // one sample with an unstalled pipe; result must appear exactly 2 cycles after the transfer
    task automatic send_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W+1:0] exp);
        dataa = a; datab = b; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({name, "_lat1"}, {{(W+1){1'b0}}, out_valid}, '0);
        step();
        check({name, "_valid"}, {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
        check(name, {sat, cout, datao}, exp);
        step();
    endtask

    initial begin
        int n;
        logic [W-1:0] ones;
        ones = '1;

        #12;
        check("rst_out", {sat, cout, datao}, '0);
        check("rst_ovalid", {{(W+1){1'b0}}, out_valid}, '0);
        check("rst_iready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
        @(negedge clock);
        reset_n = 1'b1;
        step();

        send_one("cross_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, {2'b00, 64'h0000_0001_0000_0000});
        send_one("cin_only", 64'd0, 64'd0, 1'b1, {2'b00, 64'd1});
        send_one("cin_5_7", 64'd5, 64'd7, 1'b1, {2'b00, 64'd13});
`ifdef ADDPIPE_SAT_EN
        send_one("overflow", ones, 64'd1, 1'b0, {2'b11, ones});
`else
        send_one("overflow", ones, 64'd1, 1'b0, {2'b01, 64'd0});
`endif

        // backpressure: 3 back-to-back inputs with downstream stalled
        out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0;
        dataa = 64'd1; datab = 64'd1;
        step();
        dataa = 64'd2; datab = 64'd2;
        step();
        dataa = 64'd3; datab = 64'd3;
        check("bp_full", {{(W+1){1'b0}}, in_ready}, '0);
        step();
        check("bp_held", {{(W+1){1'b0}}, in_ready}, '0);
        check("bp_out0", {{(W+1){1'b0}}, out_valid, 1'b0}, {{(W+1){1'b0}}, 2'b10});
        out_ready = 1'b1;
        check("bp_o1", {sat, cout, datao}, {2'b00, 64'd2});
        step();
        in_valid = 1'b0;
        check("bp_o2", {sat, cout, datao}, {2'b00, 64'd4});
        step();
        check("bp_o3", {sat, cout, datao}, {2'b00, 64'd6});
        step();
        check("bp_done", {{(W+1){1'b0}}, out_valid}, '0);

        // random streaming with random in_valid / out_ready
        n = 0;
        for (int cyc = 0; cyc < 20000 && n < 1000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            dataa = {$urandom, $urandom};
            datab = ($urandom_range(0, 7) == 0) ? ~dataa : {$urandom, $urandom};
            cin   = $urandom_range(0, 1);
            @(negedge clock);
            if (in_valid && in_ready) n++;
            step();
        end
        check("stream_count", n, 1000);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", q.size(), 0);

        // reset with 2 samples in flight
        out_ready = 1'b0; in_valid = 1'b1;
        dataa = 64'd10; datab = 64'd20; cin = 1'b0;
        step();
        dataa = 64'd30;
        step();
        in_valid = 1'b0;
        step();
        check("pre_rst_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
        reset_n = 1'b0;
        q.delete();
        #1;
        check("midrst_out", {sat, cout, datao}, '0);
        check("midrst_ovalid", {{(W+1){1'b0}}, out_valid}, '0);
        repeat (2) step();
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_ovalid", {{(W+1){1'b0}}, out_valid}, '0);
            check("post_rst_iready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
        end

        send_one("after_rst", 64'd100, 64'd23, 1'b1, {2'b00, 64'd124});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
